// File: rtl/prbs_sync_ctrl.sv
// Sequencing controller for the x^25+x^22+1 PRBS receive checker: seed, flush, verify, lock, monitor.
// Optional macro PRBS_SYNC_AUTO_RESYNC_EN: loss of lock reseeds automatically instead of failing.
module prbs_sync_ctrl #(
  parameter int C_SEED_LEN  = 25,
  parameter int C_LOCK_LEN  = 64,
  parameter int C_MAX_RETRY = 7,
  parameter int C_WIN_LEN   = 256,
  parameter int C_LOSS_THR  = 8,
  parameter int C_ERR_W     = 16
) (
  input  logic               CK_i,
  input  logic               XARST_i,
  input  logic               CK_EE_i,
  input  logic               START_i,
  input  logic               STOP_i,
  input  logic               CMP_i,
  output logic               BUS_RX_MODE_o,
  output logic               LOCK_o,
  output logic               FAIL_o,
  output logic [2:0]         STATE_o,
  output logic [2:0]         RETRY_o,
  output logic [C_ERR_W-1:0] ERR_CNT_o,
  output logic [C_ERR_W-1:0] BIT_CNT_o
);

  localparam int SEED_W  = (C_SEED_LEN > 1) ? $clog2(C_SEED_LEN) : 1;
  localparam int MATCH_W = $clog2(C_LOCK_LEN + 1);
  localparam int WIN_W   = (C_WIN_LEN > 1) ? $clog2(C_WIN_LEN) : 1;
  localparam int LOSS_W  = $clog2(C_LOSS_THR + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEED   = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  state_t               state_reg;
  logic [SEED_W-1:0]    seed_cnt_reg;
  logic [MATCH_W-1:0]   match_cnt_reg;
  logic [WIN_W-1:0]     win_cnt_reg;
  logic [LOSS_W-1:0]    win_err_reg;
  logic [2:0]           retry_reg;
  logic [C_ERR_W-1:0]   err_cnt_reg;
  logic [C_ERR_W-1:0]   bit_cnt_reg;
  logic                 rx_mode_reg;
  logic                 lock_reg;
  logic                 fail_reg;

  logic [MATCH_W-1:0]   match_cnt_next;
  logic                 win_wrap;
  logic [LOSS_W-1:0]    win_err_next;
  logic                 loss_of_lock;
  logic [C_ERR_W-1:0]   err_cnt_next;
  logic [C_ERR_W-1:0]   bit_cnt_next;

  // A mismatch on the wrap cycle belongs to the window that is just starting.
  always_comb begin
    match_cnt_next = match_cnt_reg + MATCH_W'(1);
    win_wrap       = (win_cnt_reg == WIN_W'(C_WIN_LEN - 1));
    win_err_next   = (win_wrap ? '0 : win_err_reg) + (CMP_i ? LOSS_W'(0) : LOSS_W'(1));
    loss_of_lock   = !CMP_i && (win_err_next == LOSS_W'(C_LOSS_THR));
    err_cnt_next   = (&err_cnt_reg) ? err_cnt_reg : err_cnt_reg + C_ERR_W'(1);
    bit_cnt_next   = (&bit_cnt_reg) ? bit_cnt_reg : bit_cnt_reg + C_ERR_W'(1);
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state_reg     <= ST_IDLE;
      seed_cnt_reg  <= '0;
      match_cnt_reg <= '0;
      win_cnt_reg   <= '0;
      win_err_reg   <= '0;
      retry_reg     <= '0;
      err_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      rx_mode_reg   <= 1'b0;
      lock_reg      <= 1'b0;
      fail_reg      <= 1'b0;
    end else if (CK_EE_i) begin
      if (STOP_i) begin
        state_reg   <= ST_IDLE;
        rx_mode_reg <= 1'b0;
        lock_reg    <= 1'b0;
      end else if (START_i) begin
        state_reg    <= ST_SEED;
        seed_cnt_reg <= '0;
        rx_mode_reg  <= 1'b1;
        lock_reg     <= 1'b0;
        retry_reg    <= 3'd1;
        err_cnt_reg  <= '0;
        bit_cnt_reg  <= '0;
        fail_reg     <= 1'b0;
      end else begin
        case (state_reg)
          ST_SEED: begin
            if (seed_cnt_reg == SEED_W'(C_SEED_LEN - 1)) begin
              state_reg   <= ST_FLUSH;
              rx_mode_reg <= 1'b0;
            end else begin
              seed_cnt_reg <= seed_cnt_reg + SEED_W'(1);
            end
          end
          // CMP_i still reflects the seeding phase here, so it is not looked at.
          ST_FLUSH: begin
            state_reg     <= ST_VERIFY;
            match_cnt_reg <= '0;
          end
          ST_VERIFY: begin
            if (CMP_i) begin
              if (match_cnt_next == MATCH_W'(C_LOCK_LEN)) begin
                state_reg   <= ST_LOCKED;
                lock_reg    <= 1'b1;
                win_cnt_reg <= '0;
                win_err_reg <= '0;
              end else begin
                match_cnt_reg <= match_cnt_next;
              end
            end else if (retry_reg < 3'(C_MAX_RETRY)) begin
              retry_reg    <= retry_reg + 3'd1;
              state_reg    <= ST_SEED;
              seed_cnt_reg <= '0;
              rx_mode_reg  <= 1'b1;
            end else begin
              state_reg <= ST_FAIL;
              fail_reg  <= 1'b1;
            end
          end
          ST_LOCKED: begin
            bit_cnt_reg <= bit_cnt_next;
            if (!CMP_i) err_cnt_reg <= err_cnt_next;
            win_cnt_reg <= win_wrap ? '0 : win_cnt_reg + WIN_W'(1);
            win_err_reg <= win_err_next;
            if (loss_of_lock) begin
              lock_reg <= 1'b0;
`ifdef PRBS_SYNC_AUTO_RESYNC_EN
              state_reg    <= ST_SEED;
              seed_cnt_reg <= '0;
              rx_mode_reg  <= 1'b1;
              retry_reg    <= 3'd1;
`else
              state_reg <= ST_FAIL;
              fail_reg  <= 1'b1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign BUS_RX_MODE_o = rx_mode_reg;
  assign LOCK_o        = lock_reg;
  assign FAIL_o        = fail_reg;
  assign STATE_o       = state_reg;
  assign RETRY_o       = retry_reg;
  assign ERR_CNT_o     = err_cnt_reg;
  assign BIT_CNT_o     = bit_cnt_reg;

endmodule

// File: tb/tb_prbs_sync_ctrl.sv
// Randomised bench for prbs_sync_ctrl against a phase/elapsed-count model of the sync sequence.
module tb_prbs_sync_ctrl;

  localparam int SEED  = 25;
  localparam int LOCKN = 64;
  localparam int MAXR  = 7;
  localparam int WIN   = 256;
  localparam int THR   = 8;
  localparam int EW    = 8;
  localparam int EMAX  = (1 << EW) - 1;
`ifdef PRBS_SYNC_AUTO_RESYNC_EN
  localparam int LOSS_STATE = 1;
  localparam int LOSS_FAIL  = 0;
`else
  localparam int LOSS_STATE = 5;
  localparam int LOSS_FAIL  = 1;
`endif

  logic          CK_i = 1'b0;
  logic          XARST_i = 1'b0;
  logic          CK_EE_i = 1'b0;
  logic          START_i = 1'b0;
  logic          STOP_i = 1'b0;
  logic          CMP_i = 1'b0;
  logic          BUS_RX_MODE_o, LOCK_o, FAIL_o;
  logic [2:0]    STATE_o, RETRY_o;
  logic [EW-1:0] ERR_CNT_o, BIT_CNT_o;

  prbs_sync_ctrl #(
    .C_SEED_LEN(SEED), .C_LOCK_LEN(LOCKN), .C_MAX_RETRY(MAXR),
    .C_WIN_LEN(WIN), .C_LOSS_THR(THR), .C_ERR_W(EW)
  ) dut (
    .CK_i(CK_i), .XARST_i(XARST_i), .CK_EE_i(CK_EE_i), .START_i(START_i),
    .STOP_i(STOP_i), .CMP_i(CMP_i), .BUS_RX_MODE_o(BUS_RX_MODE_o),
    .LOCK_o(LOCK_o), .FAIL_o(FAIL_o), .STATE_o(STATE_o), .RETRY_o(RETRY_o),
    .ERR_CNT_o(ERR_CNT_o), .BIT_CNT_o(BIT_CNT_o)
  );

  always #5 CK_i = ~CK_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase = 0 idle, 1 seed, 2 flush, 3 verify, 4 locked, 5 fail.
  // 'elapsed' counts enabled cycles since the latest seed entry; 'k' counts locked cycles.
  int m_state, m_elapsed, m_retry, m_err, m_bit, m_fail, m_k, m_win, m_win_errs;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_elapsed = 0; m_retry = 0; m_err = 0; m_bit = 0;
    m_fail = 0; m_k = 0; m_win = 0; m_win_errs = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit c);
    int w;
    bit loss;
    loss = 1'b0;
    if (sp) m_state = 0;
    else if (st) begin
      m_state = 1; m_elapsed = 0; m_retry = 1; m_err = 0; m_bit = 0; m_fail = 0;
    end else begin
      case (m_state)
        1: begin m_elapsed++; if (m_elapsed == SEED) m_state = 2; end
        2: begin m_elapsed++; m_state = 3; end
        3: begin
          if (c) begin
            m_elapsed++;
            if (m_elapsed == SEED + 1 + LOCKN) begin
              m_state = 4; m_k = 0; m_win = 0; m_win_errs = 0;
            end
          end else if (m_retry < MAXR) begin
            m_retry++; m_state = 1; m_elapsed = 0;
          end else begin
            m_state = 5; m_fail = 1;
          end
        end
        4: begin
          if (m_bit < EMAX) m_bit++;
          w = (m_k + 1) / WIN;
          if (w != m_win) begin m_win = w; m_win_errs = 0; end
          if (!c) begin
            if (m_err < EMAX) m_err++;
            m_win_errs++;
            loss = (m_win_errs == THR);
          end
          m_k++;
          if (loss) begin
`ifdef PRBS_SYNC_AUTO_RESYNC_EN
            m_state = 1; m_elapsed = 0; m_retry = 1;
`else
            m_state = 5; m_fail = 1;
`endif
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit st, input bit sp, input bit c, input bit e);
    START_i = st; STOP_i = sp; CMP_i = c; CK_EE_i = e;
    @(posedge CK_i);
    if (e && XARST_i) model_step(st, sp, c);
    #2;
  endtask

  // Per-cycle scoreboard compare, away from the active edge.
  always @(negedge CK_i) begin
    chk("state", int'(STATE_o), m_state);
    chk("rx_mode", int'(BUS_RX_MODE_o), int'(m_state == 1));
    chk("lock", int'(LOCK_o), int'(m_state == 4));
    chk("fail", int'(FAIL_o), m_fail);
    chk("retry", int'(RETRY_o), m_retry);
    chk("err_cnt", int'(ERR_CNT_o), m_err);
    chk("bit_cnt", int'(BIT_CNT_o), m_bit);
  end

  task automatic run_to_lock(output int cycles);
    cycles = 0;
    while (!LOCK_o && cycles < 300) begin
      step(0, 0, 1, 1);
      cycles++;
    end
    chk("lock_reached", int'(LOCK_o), 1);
  endtask

  initial begin
    int cyc, rx_hi, n_en;
    model_reset();
    #12;
    chk("reset_state", int'(STATE_o), 0);
    chk("reset_rx", int'(BUS_RX_MODE_o), 0);
    XARST_i = 1'b1;
    step(0, 0, 1, 1);

    // Clean lock: seed length, lock latency, bit counting.
    step(1, 0, 1, 1);
    rx_hi = int'(BUS_RX_MODE_o);
    cyc = 0;
    while (!LOCK_o && cyc < 300) begin
      step(0, 0, 1, 1);
      cyc++;
      rx_hi += int'(BUS_RX_MODE_o);
    end
    chk("rx_mode_len", rx_hi, 25);
    chk("lock_latency", cyc, 90);
    for (int i = 0; i < 40; i++) step(0, 0, 1, 1);
    chk("bit_cnt_40", int'(BIT_CNT_o), 40);
    chk("err_cnt_clean", int'(ERR_CNT_o), 0);
    $display("scenario clean_lock: latency %0d rx_high %0d", cyc, rx_hi);

    // One mismatch during verify forces a reseed.
    step(1, 0, 1, 1);
    for (int i = 0; i < 36; i++) step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    chk("retry_2", int'(RETRY_o), 2);
    chk("reseed_state", int'(STATE_o), 1);
    run_to_lock(cyc);
    $display("scenario verify_error: relocked after %0d cycles", cyc);

    // Permanent mismatch exhausts all attempts.
    step(1, 0, 1, 1);
    for (int i = 0; i < 250; i++) step(0, 0, 0, 1);
    chk("fail_flag", int'(FAIL_o), 1);
    chk("fail_state", int'(STATE_o), 5);
    chk("fail_retry", int'(RETRY_o), 7);
    chk("fail_lock", int'(LOCK_o), 0);
    step(1, 0, 1, 1);
    chk("fail_cleared", int'(FAIL_o), 0);
    chk("restart_retry", int'(RETRY_o), 1);
    $display("scenario permanent_error: fail then restart");

    // Eight errors in one window: loss of lock.
    run_to_lock(cyc);
    for (int k = 0; k <= 75; k++) step(0, 0, (k % 10) != 5, 1);
    chk("loss_lock", int'(LOCK_o), 0);
    chk("loss_state", int'(STATE_o), LOSS_STATE);
    chk("loss_fail", int'(FAIL_o), LOSS_FAIL);
    chk("loss_err_cnt", int'(ERR_CNT_o), 8);
    $display("scenario loss_of_lock: state %0d", STATE_o);

    // Seven errors per window over many windows: lock kept, counters saturate.
    step(1, 0, 1, 1);
    run_to_lock(cyc);
    for (int k = 0; k < 40 * WIN; k++) begin
      step(0, 0, !((k % WIN) >= 10 && (k % WIN) <= 130 && ((k % WIN) - 10) % 20 == 0), 1);
      if (k == 4 * WIN - 1) chk("err_28", int'(ERR_CNT_o), 28);
    end
    chk("held_lock", int'(LOCK_o), 1);
    chk("err_sat", int'(ERR_CNT_o), EMAX);
    chk("bit_sat", int'(BIT_CNT_o), EMAX);
    $display("scenario sub_threshold: err %0d bit %0d", ERR_CNT_o, BIT_CNT_o);

    // Clock enable at 50%: only enabled cycles count.
    step(1, 0, 1, 1);
    rx_hi = 1;
    cyc = 0;
    while (!LOCK_o && cyc < 600) begin
      bit e;
      e = 1'($urandom_range(0, 1));
      step(0, 0, 1, e);
      cyc++;
      if (e) rx_hi += int'(BUS_RX_MODE_o);
    end
    chk("ee_rx_len", rx_hi, 25);
    step(1, 0, 1, 0);
    chk("ee_start_ignored", int'(STATE_o), 4);
    n_en = 0;
    for (int i = 0; i < 200; i++) begin
      bit e;
      e = 1'($urandom_range(0, 1));
      step(0, 0, 1, e);
      if (e) n_en++;
    end
    chk("ee_bit_cnt", int'(BIT_CNT_o), (n_en < EMAX) ? n_en : EMAX);
    $display("scenario clock_enable: %0d enabled locked cycles", n_en);

    // Simultaneous start and stop: stop wins.
    step(1, 1, 1, 1);
    chk("start_stop", int'(STATE_o), 0);
    $display("scenario start_stop: state %0d", STATE_o);

    // Asynchronous reset in the middle of seeding.
    step(1, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
    #1 XARST_i = 1'b0;
    model_reset();
    #1;
    chk("arst_rx", int'(BUS_RX_MODE_o), 0);
    chk("arst_state", int'(STATE_o), 0);
    chk("arst_retry", int'(RETRY_o), 0);
    @(negedge CK_i);
    #1 XARST_i = 1'b1;
    $display("scenario async_reset: outputs cleared");

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 299) == 0,
           $urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0);
    $display("scenario random: 3000 cycles");

    @(negedge CK_i);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prbs_sync_ctrl.md
Name: prbs_sync_ctrl

Overview:
- Sequencing controller for the x^25+x^22+1 PRBS receive checker.
- Drives the checker's BUS_RX_MODE_i to seed its LFSR from the incoming stream, then releases it to free-run.
- Qualifies lock from the checker's registered match flag (CMP), and tracks windowed bit errors.
- Declares lock, loss of lock and failure, and resynchronises.
- Sits beside the RX checker instance on the same clock and clock enable.

Parameters:
- C_SEED_LEN, 25: enabled cycles with BUS_RX_MODE_o high (LFSR length).
- C_LOCK_LEN, 64: consecutive matches required to declare lock.
- C_MAX_RETRY, 7: seed attempts allowed before FAIL.
- C_WIN_LEN, 256: enabled cycles per error-monitor window in LOCKED.
- C_LOSS_THR, 8: errors within one window that declare loss of lock.
- C_ERR_W, 16: width of the total error and bit counters.

Ports:
- CK_i  in  1  clock.
- XARST_i  in  1  asynchronous active-low reset.
- CK_EE_i  in  1  clock enable; all state advances only when high.
- START_i  in  1  start/restart request; sampled when CK_EE_i=1.
- STOP_i  in  1  stop request; sampled when CK_EE_i=1.
- CMP_i  in  1  checker match flag; H = match; registered in the checker (1 enabled-cycle latency).
- BUS_RX_MODE_o  out  1  to checker BUS_RX_MODE_i; H = load LFSR from RXD.
- LOCK_o  out  1  H while in LOCKED.
- FAIL_o  out  1  sticky H in FAIL.
- STATE_o  out  3  IDLE=0, SEED=1, FLUSH=2, VERIFY=3, LOCKED=4, FAIL=5.
- RETRY_o  out  3  seed attempts in current run.
- ERR_CNT_o  out  C_ERR_W  saturating count of mismatches seen in LOCKED.
- BIT_CNT_o  out  C_ERR_W  saturating count of bits checked in LOCKED.

Behaviour:
- Reset (XARST_i low, asynchronous): state=IDLE; all outputs 0; all internal counters 0.
- All registers update only on CK_i rising edges with CK_EE_i=1. With CK_EE_i=0, everything holds.
- Request priority: STOP_i > START_i > normal transitions.
- STOP_i in any state: go to IDLE; BUS_RX_MODE_o=0; LOCK_o=0. ERR_CNT_o, BIT_CNT_o, RETRY_o and FAIL_o hold their values.
- START_i in any state:
  - Clear ERR_CNT_o, BIT_CNT_o, RETRY_o and FAIL_o.
  - Go to SEED with seed counter=0.
  - RETRY_o=1 (first attempt).
- IDLE: BUS_RX_MODE_o=0; waits for START_i.
- SEED:
  - BUS_RX_MODE_o=1, registered and asserted on the same edge that enters SEED.
  - Held for exactly C_SEED_LEN enabled cycles, then -> FLUSH with BUS_RX_MODE_o=0.
- FLUSH: one enabled cycle. CMP_i is ignored to absorb checker latency. Then -> VERIFY with match counter=0.
- VERIFY:
  - CMP_i=1: match counter increments. Reaching C_LOCK_LEN -> LOCKED, with window counter=0 and window error count=0.
  - CMP_i=0 with RETRY_o<C_MAX_RETRY: RETRY_o+1, -> SEED.
  - CMP_i=0 with RETRY_o=C_MAX_RETRY: -> FAIL.
- LOCKED:
  - LOCK_o=1.
  - Each enabled cycle: BIT_CNT_o+1. If CMP_i=0: ERR_CNT_o+1 and window error count+1.
  - Both counters saturate at all-ones; no wrap.
  - The window counter counts 0..C_WIN_LEN-1. On wrap, the window error count is cleared. If the wrap cycle itself carries an error, the new window starts at 1.
  - Loss of lock fires on the cycle the window error count reaches C_LOSS_THR. LOCK_o drops on the next edge, with destination per Optional Feature.
  - RETRY_o is reset to 1 on loss-of-lock resync.
- FAIL: FAIL_o=1; BUS_RX_MODE_o=0; held until START_i or STOP_i. STOP_i keeps FAIL_o=1 and goes to IDLE.
- Reset mid-operation: immediate return to IDLE values; no partial seeding persists.

Optional Feature:
- Macro: PRBS_SYNC_AUTO_RESYNC_EN.
- Defined: loss of lock goes LOCKED -> SEED (automatic resync). ERR_CNT_o and BIT_CNT_o keep accumulating across resyncs.
- Undefined: loss of lock goes LOCKED -> FAIL with FAIL_o=1. Recovery requires START_i.

Test Plan:
- Error-free TX->RX loop, START_i pulse:
  - BUS_RX_MODE_o high exactly 25 enabled cycles.
  - LOCK_o rises 25+1+64 enabled cycles after SEED entry.
  - ERR_CNT_o stays 0; BIT_CNT_o increments by 1 per enabled cycle.
- Invert one RXD bit during VERIFY: RETRY_o goes 1->2, SEED is re-entered, then lock is achieved.
- Invert RXD permanently: 7 seed attempts, then FAIL_o=1, STATE_o=5, LOCK_o=0; START_i then clears FAIL_o.
- In LOCKED, inject 8 errors within 256 cycles:
  - With macro defined: LOCK_o falls, STATE_o=1, ERR_CNT_o=8.
  - Without macro: STATE_o=5.
  - Injecting 7 errors per window over several windows: lock retained, ERR_CNT_o accumulates.
- Toggle CK_EE_i at 50% during SEED and LOCKED: seed length and counters count enabled cycles only; a START_i pulse while CK_EE_i=0 is ignored.
- Same-cycle START_i+STOP_i goes to IDLE. Asserting XARST_i mid-SEED gives all outputs 0 asynchronously.
